// File: rtl/hdmi_pkg.sv
// Shared definitions for the HDMI test-pattern generator: mode encodings and the colour-bar table.
package hdmi_pkg;

  typedef enum logic [2:0] {
    MODE_GRID   = 3'd0,
    MODE_BARS   = 3'd1,
    MODE_CHECK  = 3'd2,
    MODE_GRAD   = 3'd3,
    MODE_SCROLL = 3'd4
  } mode_t;

  localparam logic [2:0] MODE_MAX = 3'd4;

  // {R,G,B} on/off per bar; element 0 is the leftmost bar (white) down to 7 (black).
  localparam logic [7:0][2:0] BAR_RGB = {
    3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
  };

  function automatic logic [7:0] full_scale(input logic on);
    return {8{on}};
  endfunction

endpackage

// File: rtl/hdmi_pattern_ctrl.sv
// Frame-start detection, frame counter, scroll offset and the frame-synchronous mode handshake.
module hdmi_pattern_ctrl
  import hdmi_pkg::*;
#(
  parameter int COORD_W     = 10,
  parameter int SCROLL_STEP = 1
) (
  input  logic               pixclk,
  input  logic               reset,
  input  logic [COORD_W-1:0] CounterX,
  input  logic [COORD_W-1:0] CounterY,
  input  logic [2:0]         mode_req,
  input  logic               mode_req_valid,
  output logic               mode_ack,
  output logic               mode_err,
  output logic [2:0]         mode_active,
  output logic [7:0]         frame_count,
  output mode_t              mode_now,
  output logic [7:0]         offset_now
);

  logic       fs;
  logic       legal;
  logic       pend_v;
  mode_t      pending;
  mode_t      active;
  logic [7:0] offset;
  logic [7:0] offset_fs;

  assign fs        = (CounterX == '0) && (CounterY == '0);
  assign legal     = (mode_req <= MODE_MAX);
  assign offset_fs = 8'(int'(frame_count) * SCROLL_STEP);

  always_ff @(posedge pixclk) begin
    if (reset) begin
      pend_v      <= 1'b0;
      pending     <= MODE_GRID;
      active      <= MODE_GRID;
      offset      <= '0;
      frame_count <= '0;
      mode_ack    <= 1'b0;
      mode_err    <= 1'b0;
    end else begin
      mode_ack <= fs && pend_v;
      mode_err <= mode_req_valid && !legal;
      if (fs) begin
        frame_count <= frame_count + 8'd1;
        offset      <= offset_fs;
        if (pend_v) begin
          active <= pending;
          pend_v <= 1'b0;
        end
      end
      // Placed after the fs apply so a same-cycle request stays pending for the next frame.
      if (mode_req_valid && legal) begin
        pending <= mode_t'(mode_req);
        pend_v  <= 1'b1;
      end
    end
  end

  // The pixel sampled on the fs cycle already belongs to the new frame's mode and offset.
  assign mode_now    = (fs && pend_v) ? pending : active;
  assign offset_now  = fs ? offset_fs : offset;
  assign mode_active = active;

endmodule

// File: rtl/hdmi_pattern_gen.sv
// Pipelined test-pattern generator: stage 1 captures pixel context, stage 2 registers the colour.
module hdmi_pattern_gen
  import hdmi_pkg::*;
#(
  parameter int COORD_W     = 10,
  parameter int COLOR_W     = 8,
  parameter int H_ACTIVE    = 640,
  parameter int BAR_COUNT   = 8,
  parameter int CHECK_LOG2  = 5,
  parameter int SCROLL_STEP = 1
) (
  input  logic               pixclk,
  input  logic               reset,
  input  logic [COORD_W-1:0] CounterX,
  input  logic [COORD_W-1:0] CounterY,
  input  logic               DrawArea,
  input  logic [2:0]         mode_req,
  input  logic               mode_req_valid,
  output logic               mode_ack,
  output logic               mode_err,
  output logic [2:0]         mode_active,
  output logic [7:0]         frame_count,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue
);

  localparam logic [COORD_W-1:0] BAR_W    = COORD_W'(H_ACTIVE / BAR_COUNT);
  localparam logic [COORD_W-1:0] BAR_LAST = COORD_W'(BAR_COUNT - 1);

  mode_t      mode_now;
  logic [7:0] offset_now;

  hdmi_pattern_ctrl #(
    .COORD_W    (COORD_W),
    .SCROLL_STEP(SCROLL_STEP)
  ) u_ctrl (
    .pixclk        (pixclk),
    .reset         (reset),
    .CounterX      (CounterX),
    .CounterY      (CounterY),
    .mode_req      (mode_req),
    .mode_req_valid(mode_req_valid),
    .mode_ack      (mode_ack),
    .mode_err      (mode_err),
    .mode_active   (mode_active),
    .frame_count   (frame_count),
    .mode_now      (mode_now),
    .offset_now    (offset_now)
  );

  logic [COORD_W-1:0] x1;
  logic [7:0]         y1;
  logic               ychk1;
  logic               de1;
  mode_t              mode1;
  logic [7:0]         off1;

  always_ff @(posedge pixclk) begin
    if (reset) begin
      x1    <= '0;
      y1    <= '0;
      ychk1 <= 1'b0;
      de1   <= 1'b0;
      mode1 <= MODE_GRID;
      off1  <= '0;
    end else begin
      x1    <= CounterX;
      y1    <= CounterY[7:0];
      ychk1 <= CounterY[CHECK_LOG2];
      de1   <= DrawArea;
      mode1 <= mode_now;
      off1  <= offset_now;
    end
  end

  logic [7:0]         xs;
  logic [1:0]         xn43;
  logic [7:0]         wmask;
  logic [7:0]         amask;
  logic [COORD_W-1:0] bar_q;
  logic [2:0]         bar_idx;
  logic [2:0]         bar_rgb;
  logic [7:0]         c_r, c_g, c_b;

  assign xs      = x1[7:0];
  assign xn43    = ~xs[4:3];
  assign wmask   = full_scale(xs == y1);
  assign amask   = full_scale((xs[7:5] == 3'd2) && (y1[7:5] == 3'd2));
  assign bar_q   = x1 / BAR_W;
  assign bar_idx = (bar_q > BAR_LAST) ? BAR_LAST[2:0] : bar_q[2:0];
  assign bar_rgb = BAR_RGB[bar_idx];

  always_comb begin
    c_r = '0;
    c_g = '0;
    c_b = '0;
    if (de1) begin
      unique case (mode1)
        MODE_GRID: begin
          c_r = ({xs[5:0] & {6{y1[4:3] == xn43}}, 2'b00} | wmask) & ~amask;
          c_g = ((xs & {8{y1[6]}}) | wmask) & ~amask;
          c_b = y1 | wmask | amask;
        end
        MODE_BARS: begin
          c_r = full_scale(bar_rgb[2]);
          c_g = full_scale(bar_rgb[1]);
          c_b = full_scale(bar_rgb[0]);
        end
        MODE_CHECK: begin
          c_r = full_scale(x1[CHECK_LOG2] ^ ychk1);
          c_g = c_r;
          c_b = c_r;
        end
        MODE_GRAD: begin
          c_r = xs;
          c_g = y1;
          c_b = xs ^ y1;
        end
        MODE_SCROLL: begin
          c_r = full_scale((xs + off1) == y1);
          c_g = c_r;
          c_b = (c_r != '0) ? 8'hFF : 8'h40;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge pixclk) begin
    if (reset) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else begin
      red   <= COLOR_W'(c_r) << (COLOR_W - 8);
      green <= COLOR_W'(c_g) << (COLOR_W - 8);
      blue  <= COLOR_W'(c_b) << (COLOR_W - 8);
    end
  end

endmodule

// File: tb/tb_hdmi_pattern_gen.sv
// Bench for hdmi_pattern_gen: behavioural model checked every cycle plus directed literal checks.
module tb_hdmi_pattern_gen;

  logic       pixclk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] CounterX = '0;
  logic [9:0] CounterY = '0;
  logic       DrawArea = 1'b0;
  logic [2:0] mode_req = '0;
  logic       mode_req_valid = 1'b0;

  logic       mode_ack, mode_err;
  logic [2:0] mode_active;
  logic [7:0] frame_count;
  logic [7:0] red, green, blue;

  logic       ack10, err10;
  logic [2:0] act10;
  logic [7:0] fc10;
  logic [9:0] red10, green10, blue10;

  int tests_run = 0;
  int tests_failed = 0;
  bit started = 0;

  always #5 pixclk = ~pixclk;

  hdmi_pattern_gen dut (
    .pixclk(pixclk), .reset(reset), .CounterX(CounterX), .CounterY(CounterY),
    .DrawArea(DrawArea), .mode_req(mode_req), .mode_req_valid(mode_req_valid),
    .mode_ack(mode_ack), .mode_err(mode_err), .mode_active(mode_active),
    .frame_count(frame_count), .red(red), .green(green), .blue(blue)
  );

  hdmi_pattern_gen #(.COLOR_W(10)) dut10 (
    .pixclk(pixclk), .reset(reset), .CounterX(CounterX), .CounterY(CounterY),
    .DrawArea(DrawArea), .mode_req(mode_req), .mode_req_valid(mode_req_valid),
    .mode_ack(ack10), .mode_err(err10), .mode_active(act10),
    .frame_count(fc10), .red(red10), .green(green10), .blue(blue10)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference colour from the pattern rules, as {r,g,b}.
  function automatic logic [23:0] exp_color(input int mode, input int cx, input int cy, input int off);
    int x, y, r, g, b, w, a, bar;
    x = cx % 256;
    y = cy % 256;
    r = 0; g = 0; b = 0;
    case (mode)
      0: begin
        w = (x == y) ? 255 : 0;
        a = ((x / 32) == 2 && (y / 32) == 2) ? 255 : 0;
        r = (((((y / 8) % 4) == ((~(x / 8)) & 3)) ? (x % 64) * 4 : 0) | w) & ~a & 255;
        g = ((((y / 64) % 2) == 1 ? x : 0) | w) & ~a & 255;
        b = (y | w | a) & 255;
      end
      1: begin
        bar = cx / 80;
        if (bar > 7) bar = 7;
        case (bar)
          0: begin r = 255; g = 255; b = 255; end
          1: begin r = 255; g = 255; end
          2: begin g = 255; b = 255; end
          3: g = 255;
          4: begin r = 255; b = 255; end
          5: r = 255;
          6: b = 255;
          default: ;
        endcase
      end
      2: if ((((cx / 32) + (cy / 32)) % 2) == 1) begin r = 255; g = 255; b = 255; end
      3: begin r = x; g = y; b = x ^ y; end
      4: if ((x + off) % 256 == y) begin r = 255; g = 255; b = 255; end else b = 64;
      default: ;
    endcase
    return {r[7:0], g[7:0], b[7:0]};
  endfunction

  int          m_fc, m_pend, m_active, m_off, m_ack, m_err;
  bit          m_pend_v, m_fs;
  logic [23:0] exp_d1, exp_out;

  always @(posedge pixclk) begin
    if (reset) begin
      m_fc = 0; m_pend = 0; m_pend_v = 0; m_active = 0; m_off = 0;
      m_ack = 0; m_err = 0; exp_d1 = '0; exp_out = '0;
    end else begin
      m_fs  = (CounterX == 0 && CounterY == 0);
      m_ack = (m_fs && m_pend_v) ? 1 : 0;
      m_err = (mode_req_valid && mode_req > 4) ? 1 : 0;
      if (m_fs) begin
        m_off = (m_fc * 1) % 256;
        m_fc  = (m_fc + 1) % 256;
        if (m_pend_v) begin
          m_active = m_pend;
          m_pend_v = 0;
        end
      end
      if (mode_req_valid && mode_req <= 4) begin
        m_pend = int'(mode_req);
        m_pend_v = 1;
      end
      exp_out = exp_d1;
      exp_d1  = DrawArea ? exp_color(m_active, int'(CounterX), int'(CounterY), m_off) : 24'h0;
    end
  end

  always @(negedge pixclk) begin
    if (started) begin
      chk("model red",   32'(red),   32'(exp_out[23:16]));
      chk("model green", 32'(green), 32'(exp_out[15:8]));
      chk("model blue",  32'(blue),  32'(exp_out[7:0]));
      chk("model red10",   32'(red10),   32'(exp_out[23:16]) << 2);
      chk("model green10", 32'(green10), 32'(exp_out[15:8]) << 2);
      chk("model blue10",  32'(blue10),  32'(exp_out[7:0]) << 2);
      chk("model mode_active", 32'(mode_active), m_active);
      chk("model frame_count", 32'(frame_count), m_fc);
      chk("model mode_ack", 32'(mode_ack), m_ack);
      chk("model mode_err", 32'(mode_err), m_err);
      chk("model fc10", 32'(fc10), m_fc);
      chk("model act10", 32'(act10), m_active);
      chk("model ack10", 32'(ack10), m_ack);
      chk("model err10", 32'(err10), m_err);
    end
  end

  task automatic cyc(input int x, input int y, input int de, input int req, input int v);
    CounterX = 10'(x);
    CounterY = 10'(y);
    DrawArea = 1'(de);
    mode_req = 3'(req);
    mode_req_valid = 1'(v);
    @(posedge pixclk);
    #1;
  endtask

  task automatic px(input int x, input int y, input int de);
    cyc(x, y, de, 0, 0);
  endtask

  // Hold a pixel for two cycles so the outputs then show exactly that pixel.
  task automatic pix2(input int x, input int y);
    px(x, y, 1);
    px(x, y, 1);
  endtask

  task automatic chk_rgb(input string name, input int r, input int g, input int b);
    chk({name, " red"},   32'(red),   r);
    chk({name, " green"}, 32'(green), g);
    chk({name, " blue"},  32'(blue),  b);
  endtask

  initial begin
    reset = 1'b1;
    px(50, 50, 1);
    started = 1;
    px(50, 50, 1);
    chk_rgb("reset", 0, 0, 0);
    chk("reset mode_active", 32'(mode_active), 0);
    chk("reset frame_count", 32'(frame_count), 0);
    chk("reset mode_ack", 32'(mode_ack), 0);
    reset = 1'b0;

    pix2(8'h10, 8'h10);
    chk_rgb("grid diag", 8'hFF, 8'hFF, 8'hFF);
    pix2(8'h45, 8'h50);
    chk_rgb("grid box", 0, 0, 8'hFF);

    cyc(8'h20, 8'h30, 1, 1, 1);
    chk("bars pending", 32'(mode_active), 0);
    px(8'h21, 8'h30, 1);
    chk("bars still pending", 32'(mode_active), 0);
    px(0, 0, 1);
    chk("bars ack", 32'(mode_ack), 1);
    chk("bars active", 32'(mode_active), 1);
    chk("frame_count 1", 32'(frame_count), 1);
    px(1, 0, 1);
    chk("bars ack pulse", 32'(mode_ack), 0);
    chk_rgb("bars first pixel", 8'hFF, 8'hFF, 8'hFF);
    pix2(639, 1);
    chk_rgb("bars last", 0, 0, 0);
    pix2(200, 1);
    chk_rgb("bars cyan", 0, 8'hFF, 8'hFF);

    cyc(5, 5, 1, 6, 1);
    chk("err pulse", 32'(mode_err), 1);
    chk("err active", 32'(mode_active), 1);
    px(6, 5, 1);
    chk("err one cycle", 32'(mode_err), 0);
    px(0, 0, 1);
    chk("err no ack", 32'(mode_ack), 0);
    chk("err active kept", 32'(mode_active), 1);
    px(1, 0, 1);

    cyc(3, 3, 1, 2, 1);
    cyc(4, 4, 1, 3, 1);
    px(0, 0, 1);
    chk("last wins ack", 32'(mode_ack), 1);
    chk("last wins active", 32'(mode_active), 3);
    px(1, 0, 1);
    chk("single ack", 32'(mode_ack), 0);
    pix2(8'h12, 8'h34);
    chk_rgb("grad", 8'h12, 8'h34, 8'h26);
    chk("grad red10", 32'(red10), 10'h048);
    pix2(8'h80, 8'h10);
    chk("grad red10 msb", 32'(red10), 10'h200);

    px(8'h55, 8'h66, 0);
    px(8'h55, 8'h66, 1);
    chk_rgb("blank", 0, 0, 0);
    px(8'h55, 8'h66, 1);
    chk_rgb("unblank", 8'h55, 8'h66, 8'h33);

    cyc(0, 0, 1, 2, 1);
    chk("same-cycle req no ack", 32'(mode_ack), 0);
    chk("same-cycle req active", 32'(mode_active), 3);
    px(1, 0, 1);
    px(0, 0, 1);
    chk("deferred ack", 32'(mode_ack), 1);
    chk("deferred active", 32'(mode_active), 2);
    px(1, 0, 1);
    pix2(32, 0);
    chk_rgb("check white", 8'hFF, 8'hFF, 8'hFF);
    pix2(32, 32);
    chk_rgb("check black", 0, 0, 0);

    cyc(40, 9, 1, 1, 1);
    px(40, 9, 1);
    chk("pre-reset red", 32'(red), 8'hFF);
    reset = 1'b1;
    px(40, 9, 1);
    chk_rgb("mid reset", 0, 0, 0);
    chk("mid reset frame_count", 32'(frame_count), 0);
    chk("mid reset active", 32'(mode_active), 0);
    reset = 1'b0;
    px(10, 9, 1);
    px(0, 0, 1);
    chk("pending discarded", 32'(mode_ack), 0);
    chk("pending discarded active", 32'(mode_active), 0);
    chk("fc after reset", 32'(frame_count), 1);
    px(1, 0, 1);

    reset = 1'b1;
    px(20, 20, 1);
    reset = 1'b0;
    cyc(7, 7, 1, 4, 1);
    px(0, 0, 1);
    chk("scroll ack", 32'(mode_ack), 1);
    chk("scroll active", 32'(mode_active), 4);
    px(1, 0, 1);
    pix2(5, 5);
    chk_rgb("scroll f0 x5", 8'hFF, 8'hFF, 8'hFF);
    pix2(4, 5);
    chk_rgb("scroll f0 x4", 0, 0, 8'h40);
    px(0, 0, 1);
    px(1, 0, 1);
    pix2(4, 5);
    chk_rgb("scroll f1 x4", 8'hFF, 8'hFF, 8'hFF);
    pix2(5, 5);
    chk_rgb("scroll f1 x5", 0, 0, 8'h40);
    px(0, 0, 1);
    px(1, 0, 1);
    pix2(3, 5);
    chk_rgb("scroll f2 x3", 8'hFF, 8'hFF, 8'hFF);
    chk("scroll fc", 32'(frame_count), 3);

    for (int i = 0; i < 252; i++) begin
      px(0, 0, 1);
      px(1, 0, 1);
    end
    chk("fc 255", 32'(frame_count), 255);
    px(0, 0, 1);
    chk("fc wrap", 32'(frame_count), 0);
    px(1, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
